imem_boot_loader: RTL

Byte-stream program loader that sits directly upstream of the RISC-V core's register interface (`addr`/`data`/`valid`). It parses a framed little-endian byte stream from a host (UART RX, JTAG bridge or testbench), assembles 32-bit instruction words, and writes them into instruction memory. While loading it holds the core in reset, then releases it. Malformed or stalled transfers latch an error and keep the core held.

---
 rtl/imem_boot_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: parses a 16-bit word count plus payload, writes words into
// instruction memory and holds the core in reset until done. Optional macro: BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            s_byte_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [ADDR_WIDTH-1:0] load_addr_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  load_valid_o,
    output logic                  core_hold_o,
    output logic                  done_o,
    output logic                  error_o
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
    localparam logic [31:0] TO_L  = 32'(TIMEOUT_CYCLES);

    state_t                  state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [15:0]             word_idx_q, word_idx_d;
    logic [1:0]              lane_q, lane_d;
    logic [23:0]             asm_q, asm_d;
    logic [31:0]             idle_q, idle_d;
    logic                    s_ready_q, s_ready_d;
    logic [ADDR_WIDTH-1:0]   load_addr_q, load_addr_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;
    logic                    core_hold_q, core_hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic                    accept_s;
    logic                    timeout_s;
    logic [15:0]             hdr_count_s;

    assign accept_s    = s_valid_i && s_ready_q;
    assign timeout_s   = (idle_q == TO_L);
    assign hdr_count_s = {s_byte_i, count_q[7:0]};

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        idle_d       = idle_q;
        load_addr_d  = load_addr_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_HDR0: begin
                idle_d = 32'd0;
                if (accept_s) begin
                    count_d = {8'd0, s_byte_i};
                    state_d = S_HDR1;
                end else begin
                    state_d = S_HDR0;
                end
            end
            S_HDR1: begin
                if (accept_s) begin
                    idle_d  = 32'd0;
                    count_d = hdr_count_s;
                    if ((hdr_count_s == 16'd0) || ({16'd0, hdr_count_s} > MAX_W)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    idle_d = 32'd0;
                    lane_d = lane_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ s_byte_i;
`endif
                    case (lane_q)
                        2'd0: asm_d[7:0]   = s_byte_i;
                        2'd1: asm_d[15:8]  = s_byte_i;
                        2'd2: asm_d[23:16] = s_byte_i;
                        default: begin
                            load_valid_d = 1'b1;
                            load_addr_d  = ADDR_WIDTH'(word_idx_q);
                            load_data_d  = DATA_WIDTH'({s_byte_i, asm_q});
                            if (word_idx_q == (count_q - 16'd1)) begin
`ifdef BOOT_CHECKSUM_EN
                                state_d = S_CSUM;
`else
                                // Extra cycle so the last write lands before the core is released
                                state_d = S_FLUSH;
`endif
                            end else begin
                                word_idx_d = word_idx_q + 16'd1;
                            end
                        end
                    endcase
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
            S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
                if (accept_s) begin
                    idle_d = 32'd0;
                    if (s_byte_i == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
`else
                state_d = S_ERR;
`endif
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        s_ready_d   = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                      (state_d == S_DATA) || (state_d == S_CSUM);
        core_hold_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_HDR0;
            count_q      <= 16'd0;
            word_idx_q   <= 16'd0;
            lane_q       <= 2'd0;
            asm_q        <= 24'd0;
            idle_q       <= 32'd0;
            s_ready_q    <= 1'b0;
            load_addr_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            idle_q       <= idle_d;
            s_ready_q    <= s_ready_d;
            load_addr_q  <= load_addr_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            core_hold_q  <= core_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign s_ready_o    = s_ready_q;
    assign load_addr_o  = load_addr_q;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign core_hold_o  = core_hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
